// File: rtl/vram_byte_sequencer.sv
// Video-fetch byte sequencer: splits each BYTES-wide VRAM word into per-CAS byte
// slots, with an optional slot delay that draws early slots from the previous word.
module vram_byte_sequencer #(
  parameter int BYTES = 2,
  parameter int DW    = 8,
  parameter int DLYW  = ($clog2(BYTES) > 1) ? $clog2(BYTES) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cpu_n,
  input  logic                ras_n,
  input  logic                cas_n,
  input  logic [BYTES*DW-1:0] vram_din,
  input  logic                de,
  input  logic                shift_en,
  input  logic [DLYW-1:0]     delay,
  output logic [DW-1:0]       dout,
  output logic                dout_valid,
  output logic                fetch_done,
  output logic                overrun
);

  localparam int             IW   = $clog2(BYTES);
  localparam logic [IW-1:0]  LAST = IW'(BYTES - 1);

  logic [IW-1:0] idx;
  logic          cas_n_old;
  logic          sh_q;
  logic [IW-1:0] d_q;
  logic          done_seen;
  logic [DW-1:0] carry [BYTES];

  logic [DW-1:0] word [BYTES];
  logic [IW-1:0] d_clamp;
  logic [IW-1:0] e_eff;
  logic          use_carry;
  logic [IW-1:0] rd_idx;
  logic [DW-1:0] rd_byte;

  // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    for (int k = 0; k < BYTES; k++) word[k] = vram_din[k*DW +: DW];

    d_clamp = IW'(delay);
    if (int'(delay) > BYTES - 1) d_clamp = LAST;

    e_eff     = sh_q ? d_q : '0;
    use_carry = (idx < e_eff);
    rd_idx    = use_carry ? IW'(BYTES + int'(idx) - int'(e_eff)) : (idx - e_eff);
    rd_byte   = use_carry ? carry[rd_idx] : word[rd_idx];
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx        <= '0;
      cas_n_old  <= 1'b1;
      sh_q       <= 1'b0;
      d_q        <= '0;
      done_seen  <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      fetch_done <= 1'b0;
      overrun    <= 1'b0;
      // NOTE: the carry array is reset so a window after reset never emits stale bytes.
      for (int k = 0; k < BYTES; k++) carry[k] <= '0;
    end else begin
      cas_n_old <= cas_n;
      if (!cpu_n) begin
        idx        <= '0;
        dout_valid <= 1'b0;
        fetch_done <= 1'b0;
        overrun    <= 1'b0;
        done_seen  <= 1'b0;
        sh_q       <= shift_en;
        d_q        <= d_clamp;
      end else begin
        dout_valid <= !ras_n && !cas_n && cas_n_old;
        fetch_done <= 1'b0;

        // CAS rising edge inside RAS closes the current slot.
        if (!ras_n && !cas_n_old && cas_n) begin
          if (idx != LAST) begin
            idx <= idx + 1'b1;
          end else if (done_seen) begin
            overrun <= 1'b1;
          end else begin
            fetch_done <= 1'b1;
            done_seen  <= 1'b1;
          end
        end

        if (!ras_n && !cas_n) begin
          dout <= rd_byte;
          if (idx == LAST) begin
            for (int k = 0; k < BYTES; k++) carry[k] <= de ? word[k] : '0;
          end
        end
      end
    end
  end

endmodule

// File: doc/vram_byte_sequencer.md
# vram_byte_sequencer

Parametrised video-fetch byte sequencer between the SDRAM VRAM port and the gate array pixel input. Splits each wide VRAM word into BYTES consecutive byte slots, one per CAS pulse inside a RAS-low window. Supports a selectable byte-slot delay with DE masking, used to align pixel data with the filtered sync timing. This generalises the fixed two-byte, one-slot-shift fetch logic on the motherboard, and adds slot-valid, fetch-done and overrun reporting.

## Interface

Parameters:
- BYTES, 2: bytes per VRAM word (2..8).
- DW, 8: byte width.
- DLYW, $clog2(BYTES) (min 1): width of `delay`.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- cpu_n  in  1  gate-array CPU phase when low. Clears slot state and latches mode.
- ras_n  in  1  VRAM row strobe, active low.
- cas_n  in  1  VRAM column strobe, active low; one pulse per byte slot.
- vram_din  in  BYTES*DW  fetched word; byte k = vram_din[k*DW +: DW].
- de  in  1  CRTC display enable; masks carried bytes.
- shift_en  in  1  enables delayed mode.
- delay  in  DLYW  slot delay D in delayed mode; values > BYTES-1 clamp to BYTES-1.
- dout  out  DW  byte to gate array.
- dout_valid  out  1  one-clk pulse on the first update of each slot.
- fetch_done  out  1  one-clk pulse when slot BYTES-1 closes.
- overrun  out  1  sticky: a CAS pulse arrived after slot BYTES-1 in the same video phase.

## Operation

- **Registers:** slot index `i` (0..BYTES-1), cas_n_old, latched mode (sh_q, d_q), carry[0..BYTES-1] (DW each), dout, dout_valid, fetch_done, overrun.
- **CPU phase (cpu_n=0)**, has priority over all other conditions:
  - i←0, dout_valid←0, fetch_done←0, overrun←0.
  - sh_q←shift_en, d_q←clamp(delay).
  - dout and carry hold.
- **Video phase (cpu_n=1), slot advance:**
  - Condition: ras_n=0 & cas_n_old=0 & cas_n=1.
  - If i<BYTES-1: i←i+1.
  - Else (i=BYTES-1): i holds and fetch_done←1 for one clk. If a fetch_done was already issued this phase, overrun←1 instead.
- **Video phase (cpu_n=1), data update:** every clk with ras_n=0 & cas_n=0.
  - Effective delay E = sh_q ? d_q : 0.
  - If i≥E: dout←word[i−E].
  - Else: dout←carry[BYTES+i−E].
  - If i=BYTES-1: carry[k]←de ? word[k] : 0, for all k.
- **dout_valid:** 1 for the single clk following a sample with ras_n=0, cas_n=0, cas_n_old=1, cpu_n=1.
- **Non-delayed mode:** E=0, so carry and de have no effect on dout.
- **Reference case:** BYTES=2, D=1.
  - Slot 0 outputs the previous word's high byte (zeroed if de was low at capture).
  - Slot 1 outputs the current low byte.

## Timing

- Reset values (async, reset_n=0): dout=0, dout_valid=0, fetch_done=0, overrun=0, i=0, cas_n_old=1, carry=0, sh_q=0, d_q=0.
- Latency: dout reflects vram_din sampled on the same edge. This is a 1-clk registered latency from the first clk where both strobes are low.
- dout is rewritten every clk both strobes stay low. The final value of each window is the stable one.
- A slot advance and a data update in the same clk cannot occur, since they require cas_n=1 and cas_n=0 respectively.
- RAS rising without a CAS rise does not advance i.
- A new RAS window within the same video phase continues from the current i. Only cpu_n=0 rewinds i.
- Mode changes on shift_en/delay take effect only after the next cpu_n=0 clk.
- Reset mid-window: all state clears immediately. The next window starts at slot 0 with zero carry.

## Test plan

- **Reset:** assert reset_n=0 mid-window → all outputs 0 asynchronously; after release, first slot with vram_din=16'hA55A, shift_en=0 → dout=8'h5A.
- **Non-delayed, BYTES=2:** word 16'h1234, two CAS pulses → dout 8'h34 then 8'h12; dout_valid pulses twice; fetch_done pulses once after 2nd CAS rise.
- **Delayed, D=1, de=1:** words 16'hBBAA then (next phase) 16'hDDCC → 2nd phase dout 8'hBB then 8'hCC.
- **DE masking:** same stimulus as the delayed case, but de=0 during the 1st fetch's slot 1 → 2nd phase slot 0 dout=8'h00, slot 1 dout=8'hCC.
- **Mode latch:** toggle shift_en during video phase → output pattern changes only after the next cpu_n=0.
- **Overrun:** BYTES=4, five CAS pulses in one phase → i saturates at 3; fetch_done pulses once; overrun=1 until cpu_n=0.
